// File: rtl/sd_data_pkg.sv
// Shared constants for the SD 1-bit write-data transmitter.
// State codes, CRC-status tokens and error codes.
package sd_data_pkg;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_START = 4'd1;
    localparam logic [3:0] S_DATA  = 4'd2;
    localparam logic [3:0] S_CRC   = 4'd3;
    localparam logic [3:0] S_STOP  = 4'd4;
    localparam logic [3:0] S_TURN  = 4'd5;
    localparam logic [3:0] S_SWAIT = 4'd6;
    localparam logic [3:0] S_STAT  = 4'd7;
    localparam logic [3:0] S_BUSYW = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;

    localparam logic [2:0] STAT_OK  = 3'b010;
    localparam logic [2:0] STAT_CRC = 3'b101;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_CRC  = 2'b01;
    localparam logic [1:0] ERR_UNDR = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

endpackage

// File: rtl/sd_crc_16.sv
// Serial CRC-16 (x^16 + x^12 + x^5 + 1), one bit per enabled clock.
// Cleared to zero by RST.
module sd_crc_16 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BITVAL,
    input  logic        Enable,
    output logic [15:0] CRC
);

    logic [15:0] crc_q;
    logic        inv;

    assign inv = BITVAL ^ crc_q[15];
    assign CRC = crc_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            crc_q <= '0;
        end else if (Enable) begin
            crc_q <= {crc_q[14:12], crc_q[11] ^ inv, crc_q[10:5],
                      crc_q[4] ^ inv, crc_q[3:0], inv};
        end
    end

endmodule

// File: rtl/sd_data_tx.sv
// SD single-line write-data transmitter: frames a block on DAT0,
// then collects the card's CRC-status token and waits out busy.
module sd_data_tx
    import sd_data_pkg::*;
#(
    parameter int BLKSIZE = 512,
    parameter int TMO     = 65535
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       DAT_out,
    output logic       DAT_oe,
    input  logic       DAT_in,
    output logic       busy,
    output logic       done,
    output logic [2:0] status,
    output logic [1:0] err
);

    localparam int BW = $clog2(BLKSIZE) + 1;
    localparam logic [BW-1:0] LAST = BW'(BLKSIZE - 1);
    localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

    logic [3:0]    state_q, state_d;
    logic [7:0]    sh_q, sh_d;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] byte_q, byte_d;
    logic [3:0]    ccnt_q, ccnt_d;
    logic [15:0]   crcsh_q, crcsh_d;
    logic [15:0]   tmo_q, tmo_d;
    logic [2:0]    status_q, status_d;
    logic [1:0]    err_q, err_d;
    logic          crc_clr_q;
    logic [15:0]   crc_val;
    logic          rdy, dout, doe;

    sd_crc_16 u_crc (
        .CLK    (CLK),
        .RST    (RST | crc_clr_q),
        .BITVAL (sh_q[7]),
        .Enable (state_q == S_DATA),
        .CRC    (crc_val)
    );

    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        ccnt_d   = ccnt_q;
        crcsh_d  = crcsh_q;
        tmo_d    = tmo_q;
        status_d = status_q;
        err_d    = err_q;
        rdy      = 1'b0;
        dout     = 1'b1;
        doe      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    status_d = '0;
                    if (data_valid) begin
                        rdy     = 1'b1;
                        sh_d    = data_in;
                        err_d   = ERR_OK;
                        state_d = S_START;
                    end else begin
                        err_d   = ERR_UNDR;
                        state_d = S_DONE;
                    end
                end
            end
            S_START: begin
                doe     = 1'b1;
                dout    = 1'b0;
                state_d = S_DATA;
            end
            S_DATA: begin
                doe   = 1'b1;
                dout  = sh_q[7];
                bit_d = bit_q + 3'd1;
                sh_d  = {sh_q[6:0], 1'b0};
                if (bit_q == 3'd7) begin
                    byte_d = byte_q + BW'(1);
                    if (byte_q == LAST) begin
                        state_d = S_CRC;
                    end else if (data_valid) begin
                        rdy  = 1'b1;
                        sh_d = data_in;
                    end else begin
                        err_d   = ERR_UNDR;
                        state_d = S_DONE;
                    end
                end
            end
            S_CRC: begin
                doe    = 1'b1;
                ccnt_d = ccnt_q + 4'd1;
                // CRC settles on the entry edge, so the first bit comes straight from it
                if (ccnt_q == 4'd0) begin
                    dout    = crc_val[15];
                    crcsh_d = {crc_val[14:0], 1'b0};
                end else begin
                    dout    = crcsh_q[15];
                    crcsh_d = {crcsh_q[14:0], 1'b0};
                end
                if (ccnt_q == 4'd15) state_d = S_STOP;
            end
            S_STOP: begin
                doe     = 1'b1;
                state_d = S_TURN;
            end
            S_TURN: begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd1) state_d = S_SWAIT;
            end
            S_SWAIT: begin
                if (!DAT_in) begin
                    state_d = S_STAT;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = ERR_TMO;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_STAT: begin
                bit_d = bit_q + 3'd1;
                if (bit_q != 3'd3) begin
                    status_d = {status_q[1:0], DAT_in};
                end else begin
                    state_d = S_BUSYW;
                    if (status_q != STAT_OK) err_d = ERR_CRC;
                end
            end
            S_BUSYW: begin
                if (DAT_in) begin
                    state_d = S_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = ERR_TMO;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            bit_d  = '0;
            byte_d = '0;
            ccnt_d = '0;
            tmo_d  = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            ccnt_q    <= '0;
            crcsh_q   <= '0;
            tmo_q     <= '0;
            status_q  <= '0;
            err_q     <= ERR_OK;
            crc_clr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            ccnt_q    <= ccnt_d;
            crcsh_q   <= crcsh_d;
            tmo_q     <= tmo_d;
            status_q  <= status_d;
            err_q     <= err_d;
            crc_clr_q <= (state_d == S_IDLE) || (state_d == S_DONE);
        end
    end

    assign data_ready = rdy;
    assign DAT_out    = dout;
    assign DAT_oe     = doe;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign status     = status_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sd_data_tx.sv
// Randomized bench for sd_data_tx: a timeline model predicts every
// output cycle by cycle from the block contents and the card's reply.
module tb_sd_data_tx;

    localparam int B   = 4;
    localparam int TMO = 16;
    localparam int L   = 256;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       DAT_in = 1'b1;
    logic       data_ready, DAT_out, DAT_oe, busy, done;
    logic [2:0] status;
    logic [1:0] err;

    sd_data_tx #(.BLKSIZE(B), .TMO(TMO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .DAT_out    (DAT_out),
        .DAT_oe     (DAT_oe),
        .DAT_in     (DAT_in),
        .busy       (busy),
        .done       (done),
        .status     (status),
        .err        (err)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    bit         in_st[L], in_v[L], in_dat[L];
    logic [7:0] in_d[L];
    bit         e_oe[L], e_out[L], e_rdy[L], e_busy[L], e_done[L], e_se[L];
    logic [2:0] e_stat;
    logic [1:0] e_err;
    int         cur = 0;
    bit         chk = 1'b0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int j = 7; j >= 0; j--) begin
            if (b[j] ^ r[15]) r = (r << 1) ^ 16'h1021;
            else r = r << 1;
        end
        return r;
    endfunction

    always @(negedge CLK) begin
        if (chk) begin
            check("busy", busy, e_busy[cur]);
            check("done", done, e_done[cur]);
            check("data_ready", data_ready, e_rdy[cur]);
            check("DAT_oe", DAT_oe, e_oe[cur]);
            if (e_oe[cur] || !e_busy[cur]) check("DAT_out", DAT_out, e_out[cur]);
            if (e_se[cur]) begin
                check("status", status, e_stat);
                check("err", err, e_err);
            end
        end
    end

    // u: index of the byte whose fetch underruns (-1 none); w: idle cycles
    // before the token start bit; b: busy cycles; rst_at: cycle to reset in
    task automatic run_txn(input int u, input bit zero, input int w,
                           input logic [2:0] tok, input int b, input int rst_at);
        int          cp[B];
        logic [7:0]  bytes[B];
        int          nb, t0, s, dc, len;
        logic [15:0] crc;
        for (int i = 0; i < L; i++) begin
            in_st[i]  = 1'b0;
            in_v[i]   = 1'($urandom);
            in_d[i]   = 8'($urandom);
            in_dat[i] = 1'($urandom);
            e_oe[i]   = 1'b0;
            e_out[i]  = 1'b1;
            e_rdy[i]  = 1'b0;
            e_busy[i] = 1'b0;
            e_done[i] = 1'b0;
            e_se[i]   = 1'b0;
        end
        for (int k = 0; k < B; k++) cp[k] = (k == 0) ? 0 : 8 * k + 1;
        nb = (u < 0) ? B : u;
        in_st[0] = 1'b1;
        for (int k = 0; k < nb; k++) begin
            in_v[cp[k]] = 1'b1;
            if (zero) in_d[cp[k]] = 8'h00;
            bytes[k] = in_d[cp[k]];
            e_rdy[cp[k]] = 1'b1;
        end
        e_stat = 3'b000;
        e_err  = 2'b00;
        if (u != 0) begin
            e_oe[1]  = 1'b1;
            e_out[1] = 1'b0;
            for (int k = 0; k < nb; k++)
                for (int j = 0; j < 8; j++) begin
                    e_oe[2 + 8 * k + j]  = 1'b1;
                    e_out[2 + 8 * k + j] = bytes[k][7 - j];
                end
        end
        if (u >= 0) begin
            in_v[cp[u]] = 1'b0;
            dc = cp[u] + 1;
            e_err = 2'b10;
        end else begin
            crc = 16'h0000;
            for (int k = 0; k < B; k++) crc = crc_byte(crc, bytes[k]);
            for (int m = 0; m < 16; m++) begin
                e_oe[8 * B + 2 + m]  = 1'b1;
                e_out[8 * B + 2 + m] = crc[15 - m];
            end
            e_oe[8 * B + 18]  = 1'b1;
            e_out[8 * B + 18] = 1'b1;
            t0 = 8 * B + 21;
            if (w >= TMO) begin
                for (int i = 0; i < TMO; i++) in_dat[t0 + i] = 1'b1;
                dc = t0 + TMO;
                e_err = 2'b11;
            end else begin
                for (int i = 0; i < w; i++) in_dat[t0 + i] = 1'b1;
                in_dat[t0 + w] = 1'b0;
                for (int j = 0; j < 3; j++) in_dat[t0 + w + 1 + j] = tok[2 - j];
                in_dat[t0 + w + 4] = 1'b1;
                e_stat = tok;
                s = t0 + w + 5;
                if (b >= TMO) begin
                    for (int i = 0; i < TMO; i++) in_dat[s + i] = 1'b0;
                    dc = s + TMO;
                    e_err = 2'b11;
                end else begin
                    for (int i = 0; i < b; i++) in_dat[s + i] = 1'b0;
                    in_dat[s + b] = 1'b1;
                    dc = s + b + 1;
                    e_err = (tok == 3'b010) ? 2'b00 : 2'b01;
                end
            end
        end
        for (int i = 1; i <= dc; i++) begin
            e_busy[i] = 1'b1;
            in_st[i]  = ($urandom_range(0, 3) == 0);
        end
        e_done[dc] = 1'b1;
        len = dc + 4;
        for (int i = dc; i < len; i++) e_se[i] = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(posedge CLK);
            #1;
            start      = in_st[i];
            data_valid = in_v[i];
            data_in    = in_d[i];
            DAT_in     = in_dat[i];
            cur        = i;
            if (i == rst_at) begin
                chk = 1'b0;
                start = 1'b0;
                data_valid = 1'b0;
                #2 RST = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_oe", DAT_oe, 0);
                check("rst_out", DAT_out, 1);
                check("rst_done", done, 0);
                check("rst_ready", data_ready, 0);
                check("rst_status", status, 0);
                check("rst_err", err, 0);
                @(posedge CLK);
                @(posedge CLK);
                #1 RST = 1'b0;
                return;
            end
            chk = 1'b1;
        end
        @(posedge CLK);
        #1 chk = 1'b0;
    endtask

    initial begin
        logic [15:0] c;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_busy", busy, 0);
        check("reset_oe", DAT_oe, 0);
        check("reset_out", DAT_out, 1);
        check("reset_done", done, 0);
        check("reset_ready", data_ready, 0);
        check("reset_status", status, 0);
        check("reset_err", err, 0);
        @(negedge CLK);
        RST = 1'b0;

        c = 16'h0000;
        repeat (512) c = crc_byte(c, 8'hFF);
        check("model_crc_512xFF", c, 16'h7FA1);
        c = 16'h0000;
        repeat (4) c = crc_byte(c, 8'h00);
        check("model_crc_4x00", c, 16'h0000);

        run_txn(-1, 1'b1, 3, 3'b010, 5, -1);
        check("zero_blk_err", err, 2'b00);
        check("zero_blk_status", status, 3'b010);

        run_txn(-1, 1'b0, 2, 3'b101, 4, -1);
        check("crc_rej_err", err, 2'b01);
        check("crc_rej_status", status, 3'b101);

        run_txn(2, 1'b0, 0, 3'b010, 0, -1);
        check("underrun_err", err, 2'b10);

        run_txn(0, 1'b0, 0, 3'b010, 0, -1);
        check("no_data_err", err, 2'b10);

        run_txn(-1, 1'b0, TMO, 3'b010, 0, -1);
        check("stat_tmo_err", err, 2'b11);
        check("stat_tmo_status", status, 3'b000);

        run_txn(-1, 1'b0, 1, 3'b010, TMO + 2, -1);
        check("busy_tmo_err", err, 2'b11);

        run_txn(-1, 1'b0, 0, 3'b010, 2, 13);
        run_txn(-1, 1'b0, 0, 3'b010, 0, -1);
        check("restart_err", err, 2'b00);

        for (int n = 0; n < 30; n++) begin
            int       u, w, b, ra;
            logic [2:0] tok;
            u   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, B - 1) : -1;
            w   = $urandom_range(0, TMO + 1);
            b   = $urandom_range(0, TMO + 1);
            tok = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom);
            ra  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 40) : -1;
            run_txn(u, 1'b0, w, tok, b, ra);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
